// File: rtl/jt1943_romarb_pkg.sv
// Shared definitions for the jt1943 ROM request arbiter.
package jt1943_romarb_pkg;

  localparam int DATA_W = 32;

  // Two-bit state encoding of the transaction sequencer.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/jt1943_rrpick.sv
// Combinational round-robin picker: finds the first requesting client
// searching upward from last+1, wrapping modulo N.
module jt1943_rrpick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          valid
);

  // Walk the N candidates in priority order; the first hit wins.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    gnt_idx = '0;
    valid   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!valid && req[(int'(last) + i) % N]) begin
        valid   = 1'b1;
        gnt_idx = IW'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/jt1943_romarb.sv
// Round-robin arbiter sharing one SDRAM read port among N ROM caches.
// One miss becomes one SDRAM read; the word is broadcast on dout and
// only the winning client sees its we bit.
module jt1943_romarb
  import jt1943_romarb_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*AW-1:0]   addr,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic              data_rdy,
  input  logic [DATA_W-1:0] sdram_data,
  output logic [DATA_W-1:0] dout,
  output logic [N-1:0]      we,
  output logic              busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t              state_q;
  logic [IW-1:0]       gnt_q;
  logic [IW-1:0]       last_q;
  logic                sdram_req_q;
  logic [AW-1:0]       sdram_addr_q;
  logic [DATA_W-1:0]   dout_q;
  logic [N-1:0]        we_q;
  logic [N-1:0]        we_d;

  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic [AW-1:0]       pick_addr;

  jt1943_rrpick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (req),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .valid   (pick_valid)
  );

  // Address of the client the picker would grant this cycle.
  assign pick_addr = addr[pick_idx*AW +: AW];

  // Refill strobe for the current grant, loaded when data arrives.
  always_comb begin
    we_d        = '0;
    we_d[gnt_q] = 1'b1;
  end

  // Transaction sequencer with registered SDRAM request, data and strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      last_q       <= IW'(N - 1);
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      dout_q       <= '0;
      we_q         <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      we_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q        <= pick_idx;
            sdram_addr_q <= pick_addr;
            sdram_req_q  <= 1'b1;
            state_q      <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // data_rdy without ack here is stale and ignored.
          if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            if (data_rdy) begin
              dout_q  <= sdram_data;
              we_q    <= we_d;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_WAIT_DATA;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (data_rdy) begin
            dout_q  <= sdram_data;
            we_q    <= we_d;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_q  <= gnt_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jt1943_romarb.sv
// Directed self-checking bench for jt1943_romarb (N=4, AW=22).
module tb_jt1943_romarb;

  localparam int N  = 4;
  localparam int AW = 22;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic            data_rdy;
  logic [31:0]     sdram_data;
  logic [31:0]     dout;
  logic [N-1:0]    we;
  logic            busy;

  logic [AW-1:0]   addr_tab [N];

  int total = 0;
  int bad   = 0;

  jt1943_romarb #(.N(N), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .addr       (addr),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .sdram_data (sdram_data),
    .dout       (dout),
    .we         (we),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pack the per-client address table onto the flat address bus.
  always_comb begin
    addr = '0;
    for (int k = 0; k < N; k++) addr[k*AW +: AW] = addr_tab[k];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req        = '0;
    sdram_ack  = 1'b0;
    data_rdy   = 1'b0;
    sdram_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Serve one transaction for client g. Entered on a negedge with req set.
  // exp_lat < 0 skips the grant latency check.
  task automatic run_txn(input int g, input int exp_lat, input int ack_wait,
                         input int data_wait, input bit same, input bit drop_early,
                         input logic [31:0] data);
    int n;
    bit stable;
    logic [N-1:0] exp_we;
    exp_we    = '0;
    exp_we[g] = 1'b1;
    n = 0;
    while (!sdram_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!sdram_req) begin
      check("grant_timeout", 0, 1);
      return;
    end
    if (exp_lat >= 0) check("grant_lat", n, exp_lat);
    check("sdram_addr", sdram_addr, addr_tab[g]);
    stable = 1'b1;
    repeat (ack_wait) begin
      @(negedge clk);
      if (!sdram_req || sdram_addr !== addr_tab[g]) stable = 1'b0;
    end
    check("req_hold", stable, 1);
    sdram_ack = 1'b1;
    if (same) begin
      data_rdy   = 1'b1;
      sdram_data = data;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    if (!same) begin
      check("req_clear", sdram_req, 0);
      if (drop_early) req[g] = 1'b0;
      stable = 1'b1;
      repeat (data_wait) begin
        @(negedge clk);
        if (we !== '0) stable = 1'b0;
      end
      check("no_early_we", stable, 1);
      data_rdy   = 1'b1;
      sdram_data = data;
      @(negedge clk);
      data_rdy = 1'b0;
    end
    check("we_pulse", we, exp_we);
    check("dout", dout, data);
    req[g] = 1'b0;
    @(negedge clk);
    check("we_single", we, 0);
    check("idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    addr_tab[0] = 22'h00100;
    addr_tab[1] = 22'h0ABCD;
    addr_tab[2] = 22'h12345;
    addr_tab[3] = 22'h3FFFC;
    do_reset();

    // Reset state.
    check("rst_sdram_req", sdram_req, 0);
    check("rst_sdram_addr", sdram_addr, 0);
    check("rst_dout", dout, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);

    // Single request: ack at +2, data at +5.
    req = 4'b0001;
    run_txn(0, 1, 0, 2, 1'b0, 1'b0, 32'hDEADBEEF);

    // All four requesting from reset; client 0 re-misses after its refill.
    do_reset();
    req = 4'b1111;
    run_txn(0, 1, 1, 0, 1'b0, 1'b0, 32'h11110000);
    addr_tab[0] = 22'h00200;
    req[0] = 1'b1;
    run_txn(1, 1, 0, 1, 1'b0, 1'b0, 32'h22221111);
    run_txn(2, 1, 2, 0, 1'b0, 1'b0, 32'h33332222);
    run_txn(3, 1, 0, 3, 1'b0, 1'b0, 32'h44443333);
    run_txn(0, 1, 0, 0, 1'b0, 1'b0, 32'h55554444);

    // Ack and data in the same cycle (last=0, so client 2 wins).
    req = 4'b0100;
    run_txn(2, 1, 0, 0, 1'b1, 1'b0, 32'hA5A5C3C3);

    // Client 2 withdraws in WAIT_DATA; refill still happens, then client 3.
    do_reset();
    req = 4'b1100;
    run_txn(2, 1, 0, 1, 1'b0, 1'b1, 32'hCAFEF00D);
    run_txn(3, 1, 0, 0, 1'b0, 1'b0, 32'h0BADC0DE);

    // Make last=0, then abort client 1's transaction with reset in WAIT_DATA.
    req = 4'b0001;
    run_txn(0, 1, 0, 0, 1'b0, 1'b0, 32'h01234567);
    req = 4'b0011;
    @(negedge clk);
    check("pre_rst_addr", sdram_addr, addr_tab[1]);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    data_rdy   = 1'b1;
    sdram_data = 32'hFFFF0000;
    check("abort_we", we, 0);
    check("abort_sdram_req", sdram_req, 0);
    check("abort_busy", busy, 0);
    check("abort_dout", dout, 0);
    @(negedge clk);
    data_rdy = 1'b0;
    check("abort_stale_we", we, 0);
    check("abort_regrant", sdram_req, 1);
    run_txn(0, -1, 0, 0, 1'b0, 1'b0, 32'h89ABCDEF);
    run_txn(1, 1, 0, 0, 1'b0, 1'b0, 32'h76543210);

    // Spurious data_rdy and ack while idle.
    req        = '0;
    data_rdy   = 1'b1;
    sdram_ack  = 1'b1;
    sdram_data = 32'h12345678;
    @(negedge clk);
    data_rdy  = 1'b0;
    sdram_ack = 1'b0;
    check("spur_we", we, 0);
    check("spur_dout", dout, 32'h76543210);
    check("spur_busy", busy, 0);
    check("spur_sdram_req", sdram_req, 0);
    @(negedge clk);
    check("spur_we_late", we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt1943_romarb.md
# jt1943_romarb

Round-robin arbiter that shares one SDRAM read port among N ROM request caches (graphics, sound and main CPU ROM clients). Each client raises `req` with a 32-bit-aligned word address on a cache miss. The arbiter serialises these misses into single SDRAM read transactions. It broadcasts the returned 32-bit word and pulses the winning client's one-hot write strobe so that only that client refills its cache. It sits between the per-client ROM caches and the SDRAM controller in the game top level.

## Interface
Parameters:
- `N`, 4: number of clients; legal range 2..8.
- `AW`, 22: SDRAM word-address width.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  per-client miss request, level. Held until that client's `we` bit pulses.
- `addr`  in  N*AW  client k address in bits [k*AW +: AW].
- `sdram_req`  out  1  read request to the SDRAM controller.
- `sdram_addr`  out  AW  registered address of the granted client.
- `sdram_ack`  in  1  one-cycle pulse: controller accepted the request.
- `data_rdy`  in  1  one-cycle pulse: `sdram_data` is valid.
- `sdram_data`  in  32  read data.
- `dout`  out  32  registered copy of `sdram_data`, broadcast to all clients.
- `we`  out  N  one-hot, one-cycle refill strobe.
- `busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, WAIT_ACK, WAIT_DATA, DONE.
- IDLE:
  - If `req` is nonzero, the picker selects client g, searching upward from `last+1` modulo N.
  - Latch g into `gnt`, `addr[g]` into `sdram_addr`, set `sdram_req`=1, go to WAIT_ACK.
- WAIT_ACK:
  - Hold `sdram_req` and `sdram_addr` stable.
  - On `sdram_ack`, clear `sdram_req` and go to WAIT_DATA.
  - If `data_rdy` arrives in the same cycle as `sdram_ack`, treat it as the data: latch `dout` and go straight to DONE.
- WAIT_DATA: on `data_rdy`, `dout` <= `sdram_data`, go to DONE.
- DONE:
  - `we` = 1<<gnt for exactly this cycle; `last` <= gnt.
  - Return to IDLE.
- Request withdrawal: if a client drops `req` mid-transaction, the transaction still completes and `we` still pulses. An unwanted refill is harmless to the cache.
- `data_rdy` in IDLE or WAIT_ACK (without `sdram_ack`): ignored.
- `sdram_ack` outside WAIT_ACK: ignored.
- Fairness: a client requesting continuously waits at most N-1 other transactions.
- Reset values: `sdram_req`=0, `sdram_addr`=0, `dout`=0, `we`=0, `busy`=0, state=IDLE, `gnt`=0, `last`=N-1 (so client 0 wins first).
- Reset mid-transaction aborts with no `we` pulse. The SDRAM controller is reset by the same `rst`.

## Timing
- Grant latency: `req` sampled high in IDLE at edge t gives `sdram_req`=1 after edge t.
- `we` is asserted the cycle after the edge that samples `data_rdy` (DONE state).
- The client's cache updates at the end of DONE, so its `req` falls combinationally in the following IDLE cycle. IDLE then arbitrates with the updated `req`, and the same miss is never reissued.
- Minimum transaction length (ack and data together, same cycle): 3 cycles, IDLE→WAIT_ACK→DONE→IDLE.
- `we` and `dout` are valid in the same cycle. `dout` holds its value until the next `data_rdy`.
- Clients must sample `we` on every `clk` edge, not gated by `cen`.

## Structure
- Shared package `jt1943_romarb_pkg`: 2-bit state encoding constants `ST_IDLE`, `ST_WAIT_ACK`, `ST_WAIT_DATA`, `ST_DONE`.
- Sub-module `jt1943_rrpick`: combinational round-robin picker.
  - Inputs: `req[N]`, `last[$clog2(N)]`.
  - Outputs: `gnt_idx`, `valid`.
- The top module holds the FSM, the address mux and the output registers.

## Test plan
- Single request: `req`=0001, `addr[0]`=0x00100, ack at +2, data 0xDEADBEEF at +5. Expect `sdram_addr`=0x00100, one `we`=0001 pulse, `dout`=0xDEADBEEF.
- All four requesting from reset: grant order 0,1,2,3,0. Exactly one `we` bit per transaction, each matching its address.
- Ack and data in the same cycle: DONE is reached directly from WAIT_ACK, 3-cycle transaction, single `we` pulse.
- Client 2 drops `req` in WAIT_DATA: `we`=0100 still pulses. The next grant goes to client 3 if it is requesting.
- `rst` asserted in WAIT_DATA, then `data_rdy` the next cycle. Expect no `we`, `sdram_req`=0, state IDLE, and client 0 wins first after reset.
- Spurious `data_rdy` in IDLE: no `we` pulse and `dout` unchanged.
